// File: rtl/inventory_ctrl.sv
// Purpose: four-slot item counter with vend/restock requests, round-robin arbitration and a reset-time clear sweep.
// Latency: grant edge N -> ack pulse during the cycle after edge N+3 -> back in IDLE after edge N+4.
// Backpressure: level requests are held until their ack; busy is high whenever the FSM is not idle.
module inventory_ctrl #(
  parameter int unsigned MAX_QTY  = 15,
  parameter int unsigned INIT_QTY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vend_req,
  input  logic [1:0] vend_slot,
  input  logic       restock_req,
  input  logic [1:0] restock_slot,
  input  logic [3:0] restock_qty,
  input  logic [1:0] rd_slot,
  output logic [3:0] rd_qty,
  output logic       vend_ack,
  output logic       vend_ok,
  output logic       vend_empty,
  output logic       restock_ack,
  output logic       restock_sat,
  output logic       busy
);

  localparam logic [3:0] MAX4  = 4'(MAX_QTY);
  localparam logic [4:0] MAX5  = 5'(MAX_QTY);
  localparam logic [3:0] INIT4 = 4'(INIT_QTY);

  typedef enum logic [2:0] {CLEAR, IDLE, READ, WRITE, ACK} state_t;

  state_t     state;
  logic [3:0] mem [4];
  logic [1:0] clr_addr;
  logic       rr_ptr;        // 0: vend side wins a tie, 1: restock side wins
  logic       op_restock;
  logic [1:0] op_slot;
  logic [3:0] op_qty;
  logic [3:0] cur;
  logic       pend_ok;
  logic       pend_empty;
  logic       pend_sat;
  logic       ack_phase;     // 0: first ACK cycle (raise acks), 1: second (drop acks, leave)

  logic       grant_vend;
  logic       grant_restock;
  logic [4:0] sum;
  logic       mem_we;
  logic [1:0] mem_waddr;
  logic [3:0] mem_wdata;

  assign sum    = {1'b0, cur} + {1'b0, op_qty};
  assign rd_qty = mem[rd_slot];
  assign busy   = (state != IDLE);

  // Tie between both requesters goes to the side named by the round-robin pointer
  always_comb begin
    grant_vend    = vend_req && (!restock_req || !rr_ptr);
    grant_restock = restock_req && (!vend_req || rr_ptr);
  end

  // Memory write port: clear sweep, or the read-modify-write result in WRITE
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = INIT4;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = INIT4;
      end
      WRITE: begin
        mem_waddr = op_slot;
        if (op_restock) begin
          mem_we    = 1'b1;
          mem_wdata = (sum > MAX5) ? MAX4 : sum[3:0];
        end else if (cur != 4'd0) begin
          mem_we    = 1'b1;
          mem_wdata = cur - 4'd1;
        end
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Slot storage: synchronous write, asynchronous read
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered ack/flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_addr    <= 2'd0;
      rr_ptr      <= 1'b0;
      op_restock  <= 1'b0;
      op_slot     <= 2'd0;
      op_qty      <= 4'd0;
      cur         <= 4'd0;
      pend_ok     <= 1'b0;
      pend_empty  <= 1'b0;
      pend_sat    <= 1'b0;
      ack_phase   <= 1'b0;
      vend_ack    <= 1'b0;
      vend_ok     <= 1'b0;
      vend_empty  <= 1'b0;
      restock_ack <= 1'b0;
      restock_sat <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 2'd1;
          if (clr_addr == 2'd3) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (grant_vend || grant_restock) begin
            op_restock <= grant_restock;
            op_slot    <= grant_restock ? restock_slot : vend_slot;
            op_qty     <= restock_qty;
            rr_ptr     <= ~rr_ptr;
            state      <= READ;
          end
        end
        READ: begin
          cur   <= mem[op_slot];
          state <= WRITE;
        end
        WRITE: begin
          pend_sat   <= op_restock && (sum > MAX5);
          pend_ok    <= !op_restock && (cur != 4'd0);
          pend_empty <= !op_restock && (cur == 4'd0);
          state      <= ACK;
        end
        ACK: begin
          if (!ack_phase) begin
            ack_phase   <= 1'b1;
            vend_ack    <= !op_restock;
            vend_ok     <= pend_ok;
            vend_empty  <= pend_empty;
            restock_ack <= op_restock;
            restock_sat <= pend_sat;
          end else begin
            ack_phase   <= 1'b0;
            vend_ack    <= 1'b0;
            vend_ok     <= 1'b0;
            vend_empty  <= 1'b0;
            restock_ack <= 1'b0;
            restock_sat <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inventory_ctrl.sv
// Directed bench for inventory_ctrl: reset sweep, vend/restock, saturation, arbitration, mid-op reset.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
// Each scenario task does its own comparisons and bumps the shared counters.
module tb_inventory_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vend_req;
  logic [1:0] vend_slot;
  logic       restock_req;
  logic [1:0] restock_slot;
  logic [3:0] restock_qty;
  logic [1:0] rd_slot;
  logic [3:0] rd_qty;
  logic       vend_ack, vend_ok, vend_empty, restock_ack, restock_sat, busy;

  int n_checks = 0;
  int n_fail   = 0;

  inventory_ctrl #(.MAX_QTY(15), .INIT_QTY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .vend_req(vend_req), .vend_slot(vend_slot),
    .restock_req(restock_req), .restock_slot(restock_slot), .restock_qty(restock_qty),
    .rd_slot(rd_slot), .rd_qty(rd_qty),
    .vend_ack(vend_ack), .vend_ok(vend_ok), .vend_empty(vend_empty),
    .restock_ack(restock_ack), .restock_sat(restock_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one request and hold it until its ack (bounded); report what was seen.
  task automatic run_op(input logic is_restock, input logic [1:0] slot, input logic [3:0] qty,
                        output int lat, output logic got_v, output logic got_r,
                        output logic ok, output logic empty, output logic sat,
                        output int stray, output logic [3:0] rd_k2, output logic [3:0] rd_k3);
    lat = -1; got_v = 0; got_r = 0; ok = 0; empty = 0; sat = 0; stray = 0; rd_k2 = 0; rd_k3 = 0;
    @(negedge clk);
    rd_slot = slot;
    if (is_restock) begin
      restock_req = 1; restock_slot = slot; restock_qty = qty;
    end else begin
      vend_req = 1; vend_slot = slot;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) rd_k2 = rd_qty;
      if (k == 3) rd_k3 = rd_qty;
      if (!vend_ack && (vend_ok || vend_empty)) stray++;
      if (!restock_ack && restock_sat) stray++;
      if (vend_ack || restock_ack) begin
        lat = k; got_v = vend_ack; got_r = restock_ack;
        ok = vend_ok; empty = vend_empty; sat = restock_sat;
        break;
      end
    end
    vend_req = 0; restock_req = 0;
    @(negedge clk);
    if (!vend_ack && (vend_ok || vend_empty)) stray++;
    if (!restock_ack && restock_sat) stray++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    n_checks++;
    if ({busy, vend_ack, vend_ok, vend_empty, restock_ack, restock_sat} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/acks/flags=%b want 100000",
               {busy, vend_ack, vend_ok, vend_empty, restock_ack, restock_sat});
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (busy !== (i < 4)) begin
        n_fail++;
        $display("FAIL reset_busy_cycle%0d: got %b want %b", i, busy, (i < 4));
      end
      if (i < 4) @(negedge clk);
    end
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s);
      #1;
      n_checks++;
      if (rd_qty !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got %0d want 0", s, rd_qty);
      end
    end
  endtask

  task automatic test_restock_vend();
    int lat, stray; logic gv, gr, ok, em, st; logic [3:0] r2, r3;
    run_op(1, 2, 5, lat, gv, gr, ok, em, st, stray, r2, r3);
    n_checks++;
    if (lat !== 4 || {gr, gv, st} !== 3'b100 || stray !== 0) begin
      n_fail++;
      $display("FAIL restock2: got lat=%0d rack/vack/sat=%b stray=%0d want lat=4 100 stray=0",
               lat, {gr, gv, st}, stray);
    end
    n_checks++;
    if (r2 !== 4'd0 || r3 !== 4'd5 || rd_qty !== 4'd5) begin
      n_fail++;
      $display("FAIL restock2_rd: got k2=%0d k3=%0d now=%0d want 0 5 5", r2, r3, rd_qty);
    end
    run_op(0, 2, 0, lat, gv, gr, ok, em, st, stray, r2, r3);
    n_checks++;
    if (lat !== 4 || {gv, gr, ok, em} !== 4'b1010 || stray !== 0) begin
      n_fail++;
      $display("FAIL vend2: got lat=%0d vack/rack/ok/empty=%b stray=%0d want lat=4 1010 stray=0",
               lat, {gv, gr, ok, em}, stray);
    end
    n_checks++;
    if (r3 !== 4'd4 || rd_qty !== 4'd4) begin
      n_fail++;
      $display("FAIL vend2_rd: got k3=%0d now=%0d want 4 4", r3, rd_qty);
    end
  endtask

  task automatic test_vend_empty();
    int lat, stray; logic gv, gr, ok, em, st; logic [3:0] r2, r3;
    run_op(0, 1, 0, lat, gv, gr, ok, em, st, stray, r2, r3);
    n_checks++;
    if (lat !== 4 || {gv, gr, ok, em} !== 4'b1001 || stray !== 0) begin
      n_fail++;
      $display("FAIL vend_empty: got lat=%0d vack/rack/ok/empty=%b stray=%0d want lat=4 1001 stray=0",
               lat, {gv, gr, ok, em}, stray);
    end
    n_checks++;
    if (rd_qty !== 4'd0) begin
      n_fail++;
      $display("FAIL vend_empty_rd: got %0d want 0", rd_qty);
    end
  endtask

  task automatic test_saturate();
    int lat, stray; logic gv, gr, ok, em, st; logic [3:0] r2, r3;
    // {slot, qty, is_restock, expected count, expected sat/ok}
    logic [1:0] slots [5] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    logic [3:0] qtys  [5] = '{4'd12, 4'd9, 4'd0, 4'd0, 4'd0};
    logic       isr   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] expc  [5] = '{4'd12, 4'd15, 4'd15, 4'd0, 4'd14};
    logic       expf  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(isr[i], slots[i], qtys[i], lat, gv, gr, ok, em, st, stray, r2, r3);
      n_checks++;
      if (rd_qty !== expc[i] || gr !== isr[i] || gv !== !isr[i] ||
          (isr[i] ? st : ok) !== expf[i] || stray !== 0) begin
        n_fail++;
        $display("FAIL sat_step%0d: got cnt=%0d rack=%b vack=%b flag=%b stray=%0d want cnt=%0d flag=%b",
                 i, rd_qty, gr, gv, (isr[i] ? st : ok), stray, expc[i], expf[i]);
      end
    end
  endtask

  task automatic test_req_change();
    logic seen = 0; logic sat_seen = 0;
    @(negedge clk);
    restock_req = 1; restock_slot = 3; restock_qty = 4;
    @(negedge clk);
    restock_req = 0; restock_slot = 0; restock_qty = 9;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (restock_ack) begin seen = 1; sat_seen = restock_sat; end
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (seen !== 1'b1 || sat_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL req_change_ack: got ack=%b sat=%b want 1 0", seen, sat_seen);
    end
    rd_slot = 3; #1;
    n_checks++;
    if (rd_qty !== 4'd4) begin
      n_fail++;
      $display("FAIL req_change_slot3: got %0d want 4", rd_qty);
    end
    rd_slot = 0; #1;
    n_checks++;
    if (rd_qty !== 4'd14) begin
      n_fail++;
      $display("FAIL req_change_slot0: got %0d want 14", rd_qty);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    @(negedge clk);
    restock_req = 1; restock_slot = 1; restock_qty = 7;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++;
    if ({busy, restock_ack, restock_sat, vend_ack} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_state: got busy/rack/sat/vack=%b want 1000",
               {busy, restock_ack, restock_sat, vend_ack});
    end
    restock_req = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (restock_ack || vend_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_ack: got %0d acks want 0", acks);
    end
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s);
      #1;
      n_checks++;
      if (rd_qty !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_mid_slot%0d: got %0d want 0", s, rd_qty);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic order [4];
    int   n = 0;
    int   both = 0;
    @(negedge clk);
    vend_req = 1; vend_slot = 3;
    restock_req = 1; restock_slot = 3; restock_qty = 1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (vend_ack && restock_ack) both++;
      if (vend_ack || restock_ack) begin
        order[n] = restock_ack;
        n++;
      end
    end
    vend_req = 0; restock_req = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (n !== 4 || both !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d grants, %0d double acks want 4, 0", n, both);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (order[i] !== i[0]) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got side=%b want %b (0=vend 1=restock)", i, order[i], i[0]);
      end
    end
    rd_slot = 3; #1;
    n_checks++;
    if (rd_qty !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_slot3: got %0d want 1", rd_qty);
    end
  endtask

  initial begin
    vend_req = 0; vend_slot = 0;
    restock_req = 0; restock_slot = 0; restock_qty = 0;
    rd_slot = 0;
    test_reset();
    test_restock_vend();
    test_vend_empty();
    test_saturate();
    test_req_change();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/inventory_ctrl.md
INVENTORY_CTRL -- requirements
Module: inventory_ctrl

Interface
REQ-001 Parameter: MAX_QTY, default 15, saturation ceiling for any slot count (legal range 1..15).
REQ-002 Parameter: INIT_QTY, default 0, value written to every slot by the clear sweep (must be <= MAX_QTY).
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 vend_req  input  1  level request to dispense one item from vend_slot; held until vend_ack.
REQ-007 vend_slot  input  2  slot selected for a vend.
REQ-008 restock_req  input  1  level request to add restock_qty to restock_slot; held until restock_ack.
REQ-009 restock_slot  input  2  slot selected for a restock.
REQ-010 restock_qty  input  4  quantity to add.
REQ-011 rd_slot  input  2  debug/display read address.
REQ-012 rd_qty  output  4  combinational count of mem[rd_slot].
REQ-013 vend_ack  output  1  one-cycle completion pulse for a vend.
REQ-014 vend_ok  output  1  valid with vend_ack: item dispensed.
REQ-015 vend_empty  output  1  valid with vend_ack: slot was 0, nothing dispensed.
REQ-016 restock_ack  output  1  one-cycle completion pulse for a restock.
REQ-017 restock_sat  output  1  valid with restock_ack: result clipped at MAX_QTY.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 Storage SHALL be an internal 4-entry x 4-bit array: synchronous write, asynchronous read.
REQ-020 FSM states SHALL be CLEAR, IDLE, READ, WRITE, ACK.
REQ-021 CLEAR: write INIT_QTY to addresses 0,1,2,3 on four consecutive edges, then go to IDLE; requests are ignored during CLEAR.
REQ-022 IDLE with any request sampled high: latch op, slot and qty from the winning requester and go to READ; with no request, stay in IDLE.
REQ-023 Arbitration: if only one request is high, grant it; if both are high, grant the round-robin pointer's side; the pointer resets to vend and toggles to the other side after every grant.
REQ-024 READ: register cur = mem[latched slot]; go to WRITE.
REQ-025 WRITE for a vend: if cur == 0, perform no write and set vend_empty for ACK; otherwise write cur-1 and set vend_ok for ACK.
REQ-026 WRITE for a restock: compute sum = cur + qty at 5-bit width.
  - If sum > MAX_QTY: write MAX_QTY and set restock_sat.
  - Otherwise: write sum[3:0].
REQ-027 ACK: assert exactly one ack (matching the latched op) and its flags for one cycle; go to IDLE.
REQ-028 Latency: request sampled at edge N in IDLE -> ack high during the cycle after edge N+3; the FSM is back in IDLE after edge N+4.
REQ-029 A requester SHALL drop its request on the edge where it samples ack high; a request still high in IDLE is treated as a new request.
REQ-030 A restock with restock_qty = 0 SHALL complete normally: count unchanged, restock_sat = 0.
REQ-031 Slot count SHALL never wrap: it never goes below 0 and never goes above MAX_QTY.
REQ-032 rd_qty SHALL reflect a WRITE-state update from the cycle after that edge.
REQ-033 Request inputs changing after the IDLE grant edge SHALL NOT affect the operation in flight.
REQ-034 All flags SHALL be 0 whenever the corresponding ack is 0.

Reset
REQ-035 While rst_n = 0: state = CLEAR with clear address 0, pointer = vend, busy = 1, vend_ack = vend_ok = vend_empty = restock_ack = restock_sat = 0.
REQ-036 Reset asserted mid-operation SHALL discard the in-flight operation (no ack), and the CLEAR sweep SHALL re-initialise all four slots after release.

Verification
REQ-037 Reset release: busy = 1 for 4 cycles, then 0; rd_qty = INIT_QTY for all four slots.
REQ-038 Restock slot 2 qty 5, then vend slot 2 -> restock_ack with restock_sat = 0; vend_ack with vend_ok = 1; rd_qty(2) = 4; ack appears 3 cycles after the grant edge.
REQ-039 Vend slot 1 at count 0 -> vend_ack = 1, vend_empty = 1, vend_ok = 0; rd_qty(1) stays 0.
REQ-040 Slot 0 = 12, restock qty 9 (MAX_QTY = 15) -> rd_qty(0) = 15, restock_sat = 1.
REQ-041 Both requests held continuously after reset -> grants alternate vend, restock, vend, restock; neither side is granted twice in a row.
REQ-042 rst_n pulsed low during WRITE of a restock -> no restock_ack; all slots = INIT_QTY after the CLEAR sweep.
